// File: rtl/sb_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sb_cfg_pkg
// Description : Shared types and sizing helpers for the switch-block loader.
// Revision    : 1.0
// ============================================================================
package sb_cfg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int DEFAULT_N         = 4;
    localparam int DEFAULT_CHAIN_LEN = 512;
    localparam int DEFAULT_WORD_W    = 32;

    // Four sides, N SRLC32E per side, 32 bits each.
    function automatic int calc_chain_len(input int n);
        return 4 * n * 32;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sb_cfg_shifter.sv
`default_nettype none
// ============================================================================
// Module      : sb_cfg_shifter
// Description : Word PISO toward the scan chain plus SIPO capture of readback.
// Revision    : 1.0
// ============================================================================
module sb_cfg_shifter #(
    parameter int WORD_W = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic                         load,
    input  logic                         shift,
    input  logic [WORD_W-1:0]            wdata,
    input  logic [$clog2(WORD_W+1)-1:0]  nbits,
    input  logic                         sout,
    output logic                         sin,
    output logic                         last,
    output logic [WORD_W-1:0]            rdata
);

    localparam int NB_W = $clog2(WORD_W + 1);

    logic [WORD_W-1:0] r_shreg;
    logic [WORD_W-1:0] r_rdbk;
    logic [NB_W-1:0]   r_idx;
    logic [NB_W-1:0]   r_nbits;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shreg <= '0;
            r_rdbk  <= '0;
            r_idx   <= '0;
            r_nbits <= '0;
        end else if (clear) begin
            r_shreg <= '0;
            r_idx   <= '0;
        end else if (load) begin
            r_shreg <= wdata;
            r_rdbk  <= '0;
            r_idx   <= '0;
            r_nbits <= nbits;
        end else if (shift) begin
            // Bit k of readback is the k-th bit leaving the chain in this word.
            r_shreg <= r_shreg >> 1;
            r_rdbk  <= r_rdbk | (WORD_W'(sout) << r_idx);
            r_idx   <= r_idx + NB_W'(1);
        end
    end

    assign sin   = r_shreg[0];
    assign last  = ((r_idx + NB_W'(1)) == r_nbits);
    assign rdata = r_rdbk;

endmodule
`default_nettype wire

// File: rtl/sb_config_loader.sv
`default_nettype none
// ============================================================================
// Module      : sb_config_loader
// Description : Loads config words bit-serially into the switch-block scan
//               chain and returns the bits displaced from it as readback.
// Revision    : 1.0
// ============================================================================
module sb_config_loader
    import sb_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = calc_chain_len(DEFAULT_N),
    parameter int WORD_W    = DEFAULT_WORD_W
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    input  logic                           abort,
    input  logic [WORD_W-1:0]              wdata,
    input  logic                           wvalid,
    output logic                           wready,
    output logic [WORD_W-1:0]              rdata,
    output logic                           rvalid,
    output logic                           scan_ce,
    output logic                           scan_sin,
    input  logic                           scan_sout,
    output logic                           busy,
    output logic                           done,
    output logic [$clog2(CHAIN_LEN+1)-1:0] bit_cnt
);

    localparam int                CNT_W = $clog2(CHAIN_LEN + 1);
    localparam int                NB_W  = $clog2(WORD_W + 1);
    localparam logic [CNT_W-1:0]  C_LEN = CNT_W'(CHAIN_LEN);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_load;
    logic              w_shift;
    logic              w_clear;
    logic              w_cnt_clr;
    logic              w_cnt_inc;
    logic              w_rvalid_nxt;
    logic              w_last;
    logic [CNT_W-1:0]  w_remaining;
    logic [NB_W-1:0]   w_word_bits;
    logic [CNT_W-1:0]  r_bit_cnt;
    logic              r_wready;
    logic              r_scan_ce;
    logic              r_busy;
    logic              r_done;
    logic              r_rvalid;

    // Final word of the chain may be partial.
    always_comb begin
        w_remaining = C_LEN - r_bit_cnt;
        if (32'(w_remaining) >= 32'(WORD_W)) begin
            w_word_bits = NB_W'(WORD_W);
        end else begin
            w_word_bits = NB_W'(w_remaining);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_shift      = 1'b0;
        w_clear      = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_rvalid_nxt = 1'b0;
        if (abort) begin
            w_state_nxt = ST_IDLE;
            w_clear     = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_nxt = ST_LOAD;
                        w_cnt_clr   = 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (wvalid && r_wready) begin
                        w_state_nxt = ST_SHIFT;
                        w_load      = 1'b1;
                    end
                end
                ST_SHIFT: begin
                    w_shift   = 1'b1;
                    w_cnt_inc = 1'b1;
                    if (w_last) begin
                        w_rvalid_nxt = 1'b1;
                        w_state_nxt  = ((r_bit_cnt + CNT_W'(1)) == C_LEN) ? ST_DONE : ST_LOAD;
                    end
                end
                ST_DONE: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Outputs are flops decoded from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt <= '0;
            r_wready  <= 1'b0;
            r_scan_ce <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_rvalid  <= 1'b0;
        end else begin
            if (w_cnt_clr) begin
                r_bit_cnt <= '0;
            end else if (w_cnt_inc && (r_bit_cnt != C_LEN)) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
            r_wready  <= (w_state_nxt == ST_LOAD);
            r_scan_ce <= (w_state_nxt == ST_SHIFT);
            r_busy    <= (w_state_nxt != ST_IDLE);
            r_done    <= (w_state_nxt == ST_DONE);
            r_rvalid  <= w_rvalid_nxt;
        end
    end

    sb_cfg_shifter #(
        .WORD_W (WORD_W)
    ) u_shifter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (w_clear),
        .load   (w_load),
        .shift  (w_shift),
        .wdata  (wdata),
        .nbits  (w_word_bits),
        .sout   (scan_sout),
        .sin    (scan_sin),
        .last   (w_last),
        .rdata  (rdata)
    );

    assign wready  = r_wready;
    assign scan_ce = r_scan_ce;
    assign busy    = r_busy;
    assign done    = r_done;
    assign rvalid  = r_rvalid;
    assign bit_cnt = r_bit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sb_config_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_sb_config_loader
// Description : Self-checking bench; scan chains modelled as bit queues.
// Revision    : 1.0
// ============================================================================
module tb_sb_config_loader;

    localparam int LEN   = 512;
    localparam int W     = 32;
    localparam int NW    = LEN / W;
    localparam int LEN_S = 40;
    localparam int CW    = $clog2(LEN + 1);
    localparam int CWS   = $clog2(LEN_S + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          start = 1'b0, abort = 1'b0, wvalid = 1'b0;
    logic [W-1:0]  wdata = '0;
    logic          wready, rvalid, scan_ce, scan_sin, busy, done;
    logic [W-1:0]  rdata;
    logic [CW-1:0] bit_cnt;
    logic          scan_sout = 1'b0;

    logic           s_start = 1'b0, s_wvalid = 1'b0;
    logic [W-1:0]   s_wdata = '0;
    logic           s_wready, s_rvalid, s_scan_ce, s_scan_sin, s_busy, s_done;
    logic [W-1:0]   s_rdata;
    logic [CWS-1:0] s_bit_cnt;
    logic           s_scan_sout = 1'b0;

    sb_config_loader #(.CHAIN_LEN(LEN), .WORD_W(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .wdata(wdata), .wvalid(wvalid), .wready(wready),
        .rdata(rdata), .rvalid(rvalid), .scan_ce(scan_ce), .scan_sin(scan_sin),
        .scan_sout(scan_sout), .busy(busy), .done(done), .bit_cnt(bit_cnt)
    );

    sb_config_loader #(.CHAIN_LEN(LEN_S), .WORD_W(W)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .start(s_start), .abort(1'b0),
        .wdata(s_wdata), .wvalid(s_wvalid), .wready(s_wready),
        .rdata(s_rdata), .rvalid(s_rvalid), .scan_ce(s_scan_ce), .scan_sin(s_scan_sin),
        .scan_sout(s_scan_sout), .busy(s_busy), .done(s_done), .bit_cnt(s_bit_cnt)
    );

    // Chain models: index 0 is the bit currently presented on SOUT.
    bit chain_q[$];
    bit chain_s[$];

    always @(posedge clk) begin
        if (chain_q.size() == 0) for (int i = 0; i < LEN; i++) chain_q.push_back(1'b0);
        if (scan_ce === 1'b1) begin
            chain_q.push_back(scan_sin);
            void'(chain_q.pop_front());
            scan_sout <= chain_q[0];
        end
    end

    always @(posedge clk) begin
        if (chain_s.size() == 0) for (int i = 0; i < LEN_S; i++) chain_s.push_back(1'b0);
        if (s_scan_ce === 1'b1) begin
            chain_s.push_back(s_scan_sin);
            void'(chain_s.pop_front());
            s_scan_sout <= chain_s[0];
        end
    end

    int           ce_n = 0, rv_n = 0, done_n = 0;
    logic [W-1:0] rd_log [0:1023];
    int           sce_n = 0, srv_n = 0, sdone_n = 0;
    logic [W-1:0] srd_log [0:15];

    always @(negedge clk) begin
        if (scan_ce === 1'b1) ce_n <= ce_n + 1;
        if (done === 1'b1) done_n <= done_n + 1;
        if (rvalid === 1'b1) begin
            rd_log[rv_n % 1024] <= rdata;
            rv_n <= rv_n + 1;
        end
        if (s_scan_ce === 1'b1) sce_n <= sce_n + 1;
        if (s_done === 1'b1) sdone_n <= sdone_n + 1;
        if (s_rvalid === 1'b1) begin
            srd_log[srv_n % 16] <= s_rdata;
            srv_n <= srv_n + 1;
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] pack(input bit q[$], input int off, input int n);
        logic [W-1:0] v = '0;
        for (int b = 0; b < n; b++) v[b] = q[off + b];
        return v;
    endfunction

    task automatic wait_ready(output bit ok);
        int t = 0;
        while (wready !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        ok = (wready === 1'b1);
        if (!ok) check("wready_timeout", 64'(wready), 64'(1));
    endtask

    task automatic run_load(input string tag, input logic [W-1:0] words [NW], input int gap,
                            input int exp_ce, input int exp_rv, input int exp_done);
        bit q0[$];
        int ce0, rv0, d0, t;
        bit ok;
        q0  = chain_q;
        ce0 = ce_n; rv0 = rv_n; d0 = done_n;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check({tag, "_busy_on_start"}, 64'(busy), 64'(1));
        check({tag, "_cnt_on_start"}, 64'(bit_cnt), 64'(0));
        for (int i = 0; i < NW; i++) begin
            if (gap > 0) begin
                wvalid = 1'b0;
                wait_ready(ok);
                repeat (gap) @(negedge clk);
            end
            wdata  = words[i];
            wvalid = 1'b1;
            wait_ready(ok);
            if (!ok) break;
            @(negedge clk);
        end
        wvalid = 1'b0;
        t = 0;
        while (done_n == d0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check({tag, "_ce_cycles"}, 64'(ce_n - ce0), 64'(exp_ce));
        check({tag, "_rvalids"}, 64'(rv_n - rv0), 64'(exp_rv));
        check({tag, "_done_pulses"}, 64'(done_n - d0), 64'(exp_done));
        check({tag, "_bit_cnt"}, 64'(bit_cnt), 64'(LEN));
        check({tag, "_busy_after"}, 64'(busy), 64'(0));
        for (int j = 0; j < NW; j++) begin
            check($sformatf("%s_chain_w%0d", tag, j), 64'(pack(chain_q, j * W, W)), 64'(words[j]));
            check($sformatf("%s_rdata_w%0d", tag, j), 64'(rd_log[(rv0 + j) % 1024]),
                  64'(pack(q0, j * W, W)));
        end
    endtask

    typedef struct {
        string       tag;
        logic [31:0] base;
        int          mode;   // 0 incrementing, 1 constant, 2 random
        int          gap;
        int          exp_ce;
        int          exp_rv;
        int          exp_done;
    } vec_t;

    vec_t         vecs [5];
    logic [W-1:0] words [NW];
    int           t, b0, d0, rv0;

    initial begin
        vecs[0] = '{"inc",      32'hA5A5_0001, 0, 0, LEN, NW, 1};
        vecs[1] = '{"const",    32'hFFFF_0000, 1, 0, LEN, NW, 1};
        vecs[2] = '{"gap5",     32'hA5A5_0001, 0, 5, LEN, NW, 1};
        vecs[3] = '{"rnd_gap",  32'h0,         2, int'($urandom_range(1, 4)), LEN, NW, 1};
        vecs[4] = '{"rnd",      32'h0,         2, 0, LEN, NW, 1};

        repeat (3) @(negedge clk);
        check("rst_wready", 64'(wready), 64'(0));
        check("rst_rvalid", 64'(rvalid), 64'(0));
        check("rst_scan_ce", 64'(scan_ce), 64'(0));
        check("rst_scan_sin", 64'(scan_sin), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_rdata", 64'(rdata), 64'(0));
        check("rst_bit_cnt", 64'(bit_cnt), 64'(0));
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            for (int i = 0; i < NW; i++) begin
                case (vecs[v].mode)
                    0:       words[i] = vecs[v].base + 32'(i);
                    1:       words[i] = vecs[v].base;
                    default: words[i] = $urandom;
                endcase
            end
            run_load(vecs[v].tag, words, vecs[v].gap, vecs[v].exp_ce, vecs[v].exp_rv, vecs[v].exp_done);
        end

        // Short chain: second word is partial, only its low 8 bits enter.
        for (int pass = 0; pass < 2; pass++) begin
            d0 = sdone_n; rv0 = srv_n; b0 = sce_n;
            @(negedge clk) s_start = 1'b1;
            @(negedge clk) s_start = 1'b0;
            for (int i = 0; i < 2; i++) begin
                s_wdata  = (pass == 1) ? 32'h0 : ((i == 0) ? 32'h1234_5678 : 32'hFFFF_FFAB);
                s_wvalid = 1'b1;
                t = 0;
                while (s_wready !== 1'b1 && t < 200) begin
                    @(negedge clk);
                    t++;
                end
                check("s_wready_seen", 64'(s_wready), 64'(1));
                @(negedge clk);
            end
            s_wvalid = 1'b0;
            repeat (40) @(negedge clk);
            check("s_ce_cycles", 64'(sce_n - b0), 64'(LEN_S));
            check("s_done_pulses", 64'(sdone_n - d0), 64'(1));
            check("s_rvalids", 64'(srv_n - rv0), 64'(2));
            check("s_bit_cnt", 64'(s_bit_cnt), 64'(LEN_S));
            if (pass == 0) begin
                check("s_chain_w0", 64'(pack(chain_s, 0, 32)), 64'h1234_5678);
                check("s_chain_w1", 64'(pack(chain_s, 32, 8)), 64'hAB);
                check("s_rdata_w1_zero", 64'(srd_log[(rv0 + 1) % 16]), 64'h0);
            end else begin
                check("s_rdata_w0", 64'(srd_log[rv0 % 16]), 64'h1234_5678);
                check("s_rdata_w1", 64'(srd_log[(rv0 + 1) % 16]), 64'h0000_00AB);
            end
        end

        // Abort part-way through the fourth word.
        d0 = done_n; rv0 = rv_n;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        wdata  = $urandom;
        wvalid = 1'b1;
        t = 0;
        while (bit_cnt != CW'(100) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("abort_reach_100", 64'(bit_cnt), 64'(100));
        abort  = 1'b1;
        wvalid = 1'b0;
        @(negedge clk) abort = 1'b0;
        check("abort_scan_ce", 64'(scan_ce), 64'(0));
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_wready", 64'(wready), 64'(0));
        check("abort_bit_cnt", 64'(bit_cnt), 64'(100));
        repeat (40) @(negedge clk);
        check("abort_no_done", 64'(done_n - d0), 64'(0));
        check("abort_rvalids", 64'(rv_n - rv0), 64'(3));
        check("abort_cnt_held", 64'(bit_cnt), 64'(100));
        for (int i = 0; i < NW; i++) words[i] = $urandom;
        run_load("reload", words, 0, LEN, NW, 1);

        // START while busy is ignored, then asynchronous reset mid-shift.
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        wdata  = $urandom;
        wvalid = 1'b1;
        t = 0;
        while (scan_ce !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        b0 = int'(bit_cnt);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        check("busy_start_ignored_cnt", 64'(bit_cnt), 64'(b0 + 1));
        check("busy_start_ignored_busy", 64'(busy), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_scan_ce", 64'(scan_ce), 64'(0));
        check("async_rst_busy", 64'(busy), 64'(0));
        check("async_rst_wready", 64'(wready), 64'(0));
        check("async_rst_bit_cnt", 64'(bit_cnt), 64'(0));
        wvalid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        check("start_abort_busy", 64'(busy), 64'(0));
        check("start_abort_wready", 64'(wready), 64'(0));
        @(negedge clk);
        check("start_abort_idle", 64'(wready), 64'(0));
        for (int i = 0; i < NW; i++) words[i] = $urandom;
        run_load("post_rst", words, 0, LEN, NW, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
